// File: rtl/feed_sched_pkg.sv
// Shared types and default sizing for the feeder sequencing block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package feed_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } feed_state_t;

    localparam int FEED_NUM_ROWS       = 4;
    localparam int FEED_BYTES_PER_WORD = 7;

endpackage

// File: rtl/feed_window_gen.sv
// Per-row window decode of the RUN step counter into shift enables and byte-valid flags.
// Latency: combinational.
// Backpressure: none; the caller gates enables when the run is frozen.
//
// Ports:
//   run    - scheduler is in RUN; all outputs are zero otherwise
//   t      - RUN step counter
//   enable - row r shifts when r <= t < r+BYTES_PER_WORD-1
//   valid  - row r presents a live byte when r <= t < r+BYTES_PER_WORD
module feed_window_gen #(
    parameter int NUM_ROWS       = 4,
    parameter int BYTES_PER_WORD = 7,
    parameter int CNT_W          = 4
) (
    input  logic                run,
    input  logic [CNT_W-1:0]    t,
    output logic [NUM_ROWS-1:0] enable,
    output logic [NUM_ROWS-1:0] valid
);

    int tv;

    always_comb begin
        enable = '0;
        valid  = '0;
        tv     = int'(t);
        for (int r = 0; r < NUM_ROWS; r++) begin
            // Each row starts one step after the row above it (systolic skew);
            // the last byte of a word is visible but needs no further shift.
            if (run && (tv >= r) && (tv < r + BYTES_PER_WORD - 1)) enable[r] = 1'b1;
            if (run && (tv >= r) && (tv < r + BYTES_PER_WORD))     valid[r]  = 1'b1;
        end
    end

endmodule

// File: rtl/feed_scheduler.sv
// Sequences one load-then-shift burst across NUM_ROWS skewed data feeders.
// Latency: accept -> 1 LOAD cycle -> BYTES_PER_WORD+NUM_ROWS-1 RUN cycles -> 1 DONE cycle.
// Backpressure: start_ready only in IDLE (requests elsewhere are dropped); optional stall freezes RUN.
//
// Optional feature macro: FEED_SCHED_STALL_EN adds the 'stall' input.
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   start_valid/ready - burst request handshake
//   abort          - cancel the burst in progress (ignored in IDLE)
//   stall          - (FEED_SCHED_STALL_EN only) freeze the RUN step counter
//   feeder_load    - per-row load pulse during LOAD
//   feeder_enable  - per-row shift enable during RUN
//   byte_valid     - per-row live-byte flag during RUN
//   busy, done     - not-IDLE indicator and one-cycle completion pulse
module feed_scheduler
    import feed_sched_pkg::*;
#(
    parameter int NUM_ROWS       = FEED_NUM_ROWS,
    parameter int BYTES_PER_WORD = FEED_BYTES_PER_WORD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic                abort,
`ifdef FEED_SCHED_STALL_EN
    input  logic                stall,
`endif
    output logic [NUM_ROWS-1:0] feeder_load,
    output logic [NUM_ROWS-1:0] feeder_enable,
    output logic [NUM_ROWS-1:0] byte_valid,
    output logic                busy,
    output logic                done
);

    localparam int                CNT_W  = $clog2(BYTES_PER_WORD + NUM_ROWS);
    localparam logic [CNT_W-1:0]  T_LAST = CNT_W'(BYTES_PER_WORD + NUM_ROWS - 2);

    feed_state_t         state;
    logic [CNT_W-1:0]    t;
    logic                stall_w;
    logic [NUM_ROWS-1:0] win_en;
    logic [NUM_ROWS-1:0] win_bv;

`ifdef FEED_SCHED_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            t           <= '0;
            feeder_load <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            feeder_load <= '0;
            done        <= 1'b0;
            // Abort wins over every other transition; in IDLE it is a no-op.
            if (abort && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                t     <= '0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_valid) begin
                            state       <= ST_LOAD;
                            feeder_load <= '1;
                            busy        <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        state <= ST_RUN;
                        t     <= '0;
                    end
                    ST_RUN: begin
                        if (!stall_w) begin
                            if (t == T_LAST) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end else begin
                                t <= t + 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        t     <= '0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ST_IDLE;
                        t     <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Held low during reset so a requester never sees a handshake that the
    // reset is about to discard.
    assign start_ready = (state == ST_IDLE) && !reset;

    feed_window_gen #(
        .NUM_ROWS       (NUM_ROWS),
        .BYTES_PER_WORD (BYTES_PER_WORD),
        .CNT_W          (CNT_W)
    ) u_window (
        .run    (state == ST_RUN),
        .t      (t),
        .enable (win_en),
        .valid  (win_bv)
    );

    // A frozen step shifts nothing, but the bytes on the feeder outputs stay live.
    assign feeder_enable = win_en & {NUM_ROWS{~stall_w}};
    assign byte_valid    = win_bv;

endmodule

// File: tb/tb_feed_scheduler.sv
// Self-checking bench: directed bursts plus random request/abort/reset traffic,
// compared every cycle against a timeline model of one burst.
// Runs the default configuration (NUM_ROWS=4, BYTES_PER_WORD=7, no stall port).
module tb_feed_scheduler;

    localparam int NR = 4;
    localparam int BW = 7;
    localparam int BURST_LEN = BW + NR + 1;   // LOAD + RUN cycles + DONE

    logic          clk;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic          abort;
    logic [NR-1:0] feeder_load;
    logic [NR-1:0] feeder_enable;
    logic [NR-1:0] byte_valid;
    logic          busy;
    logic          done;

    feed_scheduler #(.NUM_ROWS(NR), .BYTES_PER_WORD(BW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_valid   (start_valid),
        .start_ready   (start_ready),
        .abort         (abort),
        .feeder_load   (feeder_load),
        .feeder_enable (feeder_enable),
        .byte_valid    (byte_valid),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: a burst is a fixed timeline; k counts cycles since the accepting edge.
    bit m_active = 0;
    int m_k      = 0;

    // Trackers for the directed scenarios.
    int en_cnt   [NR];
    int first_en [NR];
    int last_en  [NR];
    int last_bv  [NR];
    int run_cnt;
    int load_q[$];
    int done_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_trk();
        for (int r = 0; r < NR; r++) begin
            en_cnt[r] = 0; first_en[r] = -1; last_en[r] = -1; last_bv[r] = -1;
        end
        run_cnt = 0;
        load_q.delete();
        done_q.delete();
    endtask

    task automatic check_model();
        logic [NR-1:0] e_load, e_en, e_bv;
        int tt;
        e_load = '0; e_en = '0; e_bv = '0;
        if (m_active && m_k == 1) e_load = '1;
        if (m_active && m_k >= 2 && m_k <= BURST_LEN - 1) begin
            tt = m_k - 2;
            for (int r = 0; r < NR; r++) begin
                e_en[r] = (tt >= r) && (tt < r + BW - 1);
                e_bv[r] = (tt >= r) && (tt < r + BW);
            end
        end
        chk("start_ready", 32'(start_ready), 32'(!m_active && !reset));
        chk("feeder_load", 32'(feeder_load), 32'(e_load));
        chk("feeder_enable", 32'(feeder_enable), 32'(e_en));
        chk("byte_valid", 32'(byte_valid), 32'(e_bv));
        chk("busy", 32'(busy), 32'(m_active));
        chk("done", 32'(done), 32'(m_active && m_k == BURST_LEN));
    endtask

    task automatic step(input logic sv, input logic ab, input logic rs);
        start_valid = sv;
        abort       = ab;
        reset       = rs;
        @(posedge clk);
        if (rs) begin
            m_active = 0;
        end else if (m_active && ab) begin
            m_active = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k > BURST_LEN) m_active = 0;
        end else if (sv) begin
            m_active = 1;
            m_k      = 1;
        end
        cyc++;
        #1;
        check_model();
        for (int r = 0; r < NR; r++) begin
            if (feeder_enable[r] === 1'b1) begin
                en_cnt[r]++;
                if (first_en[r] < 0) first_en[r] = cyc;
                last_en[r] = cyc;
            end
            if (byte_valid[r] === 1'b1) last_bv[r] = cyc;
        end
        if (busy === 1'b1 && feeder_load === '0 && done === 1'b0) run_cnt++;
        if (feeder_load !== '0) load_q.push_back(cyc);
        if (done === 1'b1) done_q.push_back(cyc);
    endtask

    initial begin
        int c0;
        start_valid = 1'b0;
        abort       = 1'b0;
        reset       = 1'b1;

        // Reset state, including start_ready held low during reset.
        step(0, 0, 1);
        step(0, 0, 1);
        chk("rst_ready_low", 32'(start_ready), 32'd0);
        step(0, 0, 0);
        chk("rst_ready_high", 32'(start_ready), 32'd1);

        // Single burst: latency, skew, per-row enable counts.
        clear_trk();
        step(1, 0, 0);
        c0 = cyc;
        chk("single_load", 32'(feeder_load), 32'hF);
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        chk("single_done_cnt", 32'(done_q.size()), 32'd1);
        if (done_q.size() > 0) chk("single_done_lat", 32'(done_q[0] - c0), 32'd11);
        chk("single_run_len", 32'(run_cnt), 32'd10);
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("en_count_row%0d", r), 32'(en_cnt[r]), 32'd6);
            chk($sformatf("en_first_row%0d", r), 32'(first_en[r] - c0), 32'(1 + r));
            chk($sformatf("en_last_row%0d", r), 32'(last_en[r] - c0), 32'(6 + r));
            chk($sformatf("bv_last_row%0d", r), 32'(last_bv[r] - c0), 32'(7 + r));
        end

        // Back-to-back with start_valid held high.
        clear_trk();
        for (int i = 0; i < 26; i++) step(1, 0, 0);
        chk("b2b_loads", 32'(load_q.size() >= 2), 32'd1);
        if (load_q.size() >= 2 && done_q.size() >= 1) begin
            chk("b2b_gap", 32'(load_q[1] - done_q[0]), 32'd2);
            chk("b2b_period", 32'(load_q[1] - load_q[0]), 32'd13);
        end
        for (int i = 0; i < 14; i++) step(0, 0, 0);

        // Abort in IDLE does not block accept.
        step(1, 1, 0);
        chk("idle_abort_accept", 32'(feeder_load), 32'hF);
        // Abort at t=4 (LOAD cycle, then t=0..4).
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        clear_trk();
        step(0, 1, 0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_outputs", 32'({feeder_load, feeder_enable, byte_valid, done}), 32'd0);
        step(1, 0, 0);
        chk("abort_restart", 32'(feeder_load), 32'hF);
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        chk("abort_restart_done", 32'(done_q.size()), 32'd1);

        // Reset at t=5, then a full burst.
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        step(0, 0, 1);
        chk("midrun_reset", 32'({busy, feeder_load, feeder_enable, byte_valid, done}), 32'd0);
        step(0, 0, 0);
        clear_trk();
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0);
        chk("post_reset_run_len", 32'(run_cnt), 32'd10);
        chk("post_reset_done", 32'(done_q.size()), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/feed_scheduler.md
FEED_SCHEDULER -- requirements
Module: feed_scheduler

Interface
REQ-001 Parameter NUM_ROWS, default 4: number of data_feeder instances sequenced, one per systolic row.
REQ-002 Parameter BYTES_PER_WORD, default 7: bytes held per feeder burst (56-bit word).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start_valid  input  1  requester asks for one burst on all rows.
REQ-006 start_ready  output  1  scheduler can accept a burst.
REQ-007 abort  input  1  cancels the burst in progress.
REQ-008 feeder_load  output  NUM_ROWS  per-row load pulse; drives each feeder's reset/load pin.
REQ-009 feeder_enable  output  NUM_ROWS  per-row shift enable.
REQ-010 byte_valid  output  NUM_ROWS  row r feeder output carries a live byte this cycle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at burst completion.

Function
REQ-013 FSM states IDLE, LOAD, RUN, DONE; all outputs registered or decoded from registered state only.
REQ-014 start_ready = 1 only in IDLE; accept = start_valid && start_ready at a posedge; IDLE->LOAD on accept.
REQ-015 LOAD lasts exactly 1 cycle: feeder_load = all ones, enables and byte_valid zero; LOAD->RUN, step counter t cleared to 0.
REQ-016 RUN: t increments by 1 each cycle, 0 .. BYTES_PER_WORD+NUM_ROWS-2; counter width $clog2(BYTES_PER_WORD+NUM_ROWS).
REQ-017 In RUN, feeder_enable[r] = 1 iff r <= t < r+BYTES_PER_WORD-1 (BYTES_PER_WORD-1 shifts per row, row skew 1 cycle).
REQ-018 In RUN, byte_valid[r] = 1 iff r <= t < r+BYTES_PER_WORD.
REQ-019 RUN->DONE when t = BYTES_PER_WORD+NUM_ROWS-2; DONE lasts 1 cycle with done = 1, then DONE->IDLE.
REQ-020 start_valid outside IDLE is ignored (not queued); a burst requested during DONE is accepted on the following IDLE cycle at the earliest.
REQ-021 abort in LOAD/RUN/DONE: next state IDLE, all outputs zero next cycle, no done pulse; abort in IDLE has no effect and does not block accept.
REQ-022 abort and accept never coincide (accept requires IDLE); abort takes priority over every other transition.

Reset
REQ-023 reset forces IDLE and t = 0 at the next posedge regardless of state, including mid-RUN.
REQ-024 Reset values: start_ready 1 (after reset deasserts), feeder_load 0, feeder_enable 0, byte_valid 0, busy 0, done 0; start_ready 0 while reset is high.

Configuration
REQ-025 Macro FEED_SCHED_STALL_EN adds input stall (1 bit, placed after abort).
REQ-026 With FEED_SCHED_STALL_EN: stall high in RUN freezes t and forces feeder_enable to 0, byte_valid holds its value; stall has no effect in IDLE/LOAD/DONE; abort overrides stall.
REQ-027 Without FEED_SCHED_STALL_EN: no stall port; RUN always advances.

Structure
REQ-028 Package feed_sched_pkg holds the state enum (feed_state_t) and default constants FEED_NUM_ROWS = 4, FEED_BYTES_PER_WORD = 7.
REQ-029 One sub-module feed_window_gen: combinational per-row window decode of t into feeder_enable/byte_valid, instantiated once with NUM_ROWS-wide outputs.

Verification (NUM_ROWS=4, BYTES_PER_WORD=7)
REQ-030 Single burst: start_valid pulse at edge E0 -> feeder_load=4'hF in cycle after E0; RUN 10 cycles; done high exactly one cycle, 11 cycles after E0; busy high throughout.
REQ-031 Skew check: during RUN, feeder_enable[0] high t=0..5, [3] high t=3..8; byte_valid[0] t=0..6, [3] t=3..9; each row exactly 6 enables.
REQ-032 Back-to-back: start_valid held high continuously -> second feeder_load pulse 2 cycles after first done (DONE->IDLE->LOAD), no overlap.
REQ-033 Abort at t=4 -> all outputs zero next cycle, state IDLE, no done; new start accepted immediately.
REQ-034 Reset asserted at t=5 for 1 cycle -> outputs at reset values; following burst runs full 10-cycle RUN.
REQ-035 With FEED_SCHED_STALL_EN: stall high for 3 cycles at t=2 -> enables zero for those cycles, done delayed by exactly 3 cycles, per-row enable count still 6.
